// File: rtl/rs_ap_ctrl_start_scheduler.sv
// Start scheduler for an ap_ctrl_chain kernel behind a relay-station start/ready pipeline.
// Host starts become head tokens, tail tokens launch the kernel, and completions return as ap_done.
module rs_ap_ctrl_start_scheduler #(
  parameter int MAX_INFLIGHT = 4,
  parameter int GRACE_PERIOD = 24,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ap_start,
  output logic             ap_ready,
  output logic             ap_done,
  input  logic             ap_continue,
  output logic             ap_idle,
  output logic             pp_if_write,
  input  logic             pp_if_full_n,
  input  logic             pp_if_empty_n,
  output logic             pp_if_read,
  output logic             kernel_start,
  input  logic             kernel_ready,
  input  logic             kernel_done,
  output logic [CNT_W-1:0] inflight,
  output logic             err_protocol,
  output logic             fsm_state
);

  localparam int GW = (GRACE_PERIOD > 1) ? $clog2(GRACE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [GW-1:0]    GRACE_END = GW'(GRACE_PERIOD - 1);

  typedef enum logic {
    GRACE = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t           state;
  logic [GW-1:0]    grace_cnt;
  logic             start_vld;
  logic [CNT_W-1:0] pending_done;
  logic [CNT_W-1:0] running;
  logic [CNT_W-1:0] inflight_nxt;
  logic [CNT_W-1:0] pending_nxt;
  logic [CNT_W-1:0] running_nxt;
  logic             grace_done;
  logic             grace_expire;
  logic             accept;
  logic             launch;
  logic             retire;
  logic             k_valid;
  logic             pend_inc;
  logic             done_bad;

  // Every transfer is a valid/ready pair that completes on a rising edge where both are high:
  // ap_start/ap_ready, pp_if_full_n/pp_if_write, pp_if_empty_n/pp_if_read,
  // kernel_start/kernel_ready and ap_done/ap_continue. Valid is held until the transfer.
  assign grace_done   = (state == RUN);
  assign grace_expire = (state == GRACE) && (grace_cnt == GRACE_END);
  assign fsm_state    = state;

  // Credit compare uses the registered count: a same-cycle retire frees nothing until next cycle.
  assign accept       = ap_start & pp_if_full_n & grace_done & (inflight < MAX_CNT);
  assign ap_ready     = accept;
  assign pp_if_write  = accept;

  assign pp_if_read   = grace_done & pp_if_empty_n & (!start_vld | kernel_ready);
  assign kernel_start = start_vld;
  assign launch       = start_vld & kernel_ready;
  assign retire       = ap_done & ap_continue;

  // A completion is only legal against a launched invocation and a free pending slot.
  assign k_valid  = kernel_done & (running != '0);
  assign pend_inc = k_valid & (pending_done != MAX_CNT);
  assign done_bad = kernel_done & ((running == '0) | (pending_done == MAX_CNT));

  always_comb begin
    inflight_nxt = inflight;
    if (accept && !retire) inflight_nxt = inflight + ONE;
    else if (retire && !accept && inflight != '0) inflight_nxt = inflight - ONE;

    pending_nxt = pending_done;
    if (pend_inc && !retire) pending_nxt = pending_done + ONE;
    else if (retire && !pend_inc && pending_done != '0) pending_nxt = pending_done - ONE;

    running_nxt = running;
    if (launch && !k_valid && running != MAX_CNT) running_nxt = running + ONE;
    else if (k_valid && !launch) running_nxt = running - ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= GRACE;
      grace_cnt    <= '0;
      start_vld    <= 1'b0;
      inflight     <= '0;
      pending_done <= '0;
      running      <= '0;
      ap_done      <= 1'b0;
      ap_idle      <= 1'b0;
      err_protocol <= 1'b0;
    end else begin
      case (state)
        GRACE: begin
          if (grace_expire) state <= RUN;
          else grace_cnt <= grace_cnt + GW'(1);
        end
        RUN:     state <= RUN;
        default: state <= GRACE;
      endcase

      if (pp_if_read) start_vld <= 1'b1;
      else if (kernel_ready) start_vld <= 1'b0;

      inflight     <= inflight_nxt;
      pending_done <= pending_nxt;
      running      <= running_nxt;
      ap_done      <= (pending_nxt != '0);
      ap_idle      <= (grace_done | grace_expire) & (inflight_nxt == '0);
      err_protocol <= err_protocol | done_bad;
    end
  end

endmodule
